seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width; SHALL be even and >= 8.
REQ-002 Parameter SHW, default 5: shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 start  in  1  operation request; accepted only when busy=0.
REQ-006 op  in  5  operation code; op[4]=0 selects a basic op, op[4]=1 selects a mul/div op.
REQ-007 a  in  WIDTH  operand A; a[SHW-1:0] is the shift amount for shift ops.
REQ-008 b  in  WIDTH  operand B; the value shifted or loaded for shift/lui ops.
REQ-009 r  out  WIDTH  result; low half (quotient) for mul/div.
REQ-010 hi  out  WIDTH  high product or remainder; 0 after basic ops.
REQ-011 z  out  1  high when r == 0.
REQ-012 v  out  1  signed overflow, add/sub only; 0 for all other ops.
REQ-013 dz  out  1  divide-by-zero flag for div ops.
REQ-014 busy  out  1  high from the cycle after acceptance until done.
REQ-015 done  out  1  one-cycle pulse when r/hi/z/v/dz become valid.

Function
REQ-016 Operands and op SHALL be latched at acceptance; later input changes SHALL NOT affect the result.
REQ-017 Basic ops (op[4]=0) use op[3:0]; op[1:0] selects the group and op[2] the variant:
- 00: add (op[2]=0) / sub (op[2]=1)
- 01: and / or
- 10: xor / lui, where lui = {b[WIDTH/2-1:0], WIDTH/2 zeros}
- 11: shift b by a[SHW-1:0]; op[2]=0 left, op[2]=1 right; op[3]=1 arithmetic right.
REQ-018 v SHALL be 1 on add when a and b share a sign and r differs from it, and on sub when a and b differ in sign and r's sign differs from a's.
REQ-019 Mul/div ops (op[4]=1) use op[1:0]: 00 signed mult, 01 unsigned multu, 10 signed div, 11 unsigned divu; op[3:2] ignored.
REQ-020 State machine states: IDLE, MUL, DIV, FIX, DONE; reset state IDLE.
REQ-021 IDLE transitions on accepted start:
- basic op -> DONE
- mult/multu -> MUL
- div/divu with b != 0 -> DIV
- div/divu with b == 0 -> DONE.
REQ-022 MUL SHALL perform radix-2 shift-add on operand magnitudes, one bit per cycle, for exactly WIDTH cycles (down-counter), then go to FIX.
REQ-023 DIV SHALL perform restoring division on magnitudes, one quotient bit per cycle, for exactly WIDTH cycles, then go to FIX.
REQ-024 FIX (1 cycle) SHALL apply signs:
- product negated if signs of a and b differ (signed op)
- quotient negated if signs differ
- remainder takes the sign of a
- then go to DONE.
REQ-025 DONE SHALL assert done for one cycle, update r/hi/z/v/dz, and return to IDLE.
REQ-026 Latency, start accepted at edge N: basic op and divide-by-zero -> done at N+1; mul/div -> done at N+WIDTH+2.
REQ-027 Divide by zero: r = all ones, hi = a, dz=1; dz SHALL be 0 for every other op.
REQ-028 Signed div of most-negative by -1: r = most-negative, hi = 0, v=0.
REQ-029 start while busy=1 SHALL be ignored with no effect on the operation in progress.
REQ-030 start in the DONE cycle SHALL be ignored; a new start is accepted from IDLE only.
REQ-031 r/hi/z/v/dz SHALL hold their last values until the next done.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, counter 0, and r, hi, z, v, dz, busy, done all 0.
REQ-033 Reset mid-operation SHALL abort the operation; no done pulse SHALL follow for it.

Verification (WIDTH=32)
REQ-034 add a=0x7FFFFFFF, b=1 -> done at N+1, r=0x80000000, v=1, z=0.
REQ-035 sra (op=0b01111) a=4, b=0x80000000 -> r=0xF8000000; lui b=0x00001234 -> r=0x12340000.
REQ-036 mult a=-3, b=5 -> done exactly at N+34, hi=0xFFFFFFFF, r=0xFFFFFFF1; busy high for 33 cycles.
REQ-037 div a=-7, b=2 -> r=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=2 -> r=3, hi=1.
REQ-038 divu a=0x55, b=0 -> done at N+1, dz=1, r=0xFFFFFFFF, hi=0x55.
REQ-039 assert rst at N+10 of a mult -> all outputs 0 and busy=0 immediately; no done; next start completes normally.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operation request in, result and status out.
interface seq_alu_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   logic             start;
   logic [4:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] hi;
   logic             z;
   logic             v;
   logic             dz;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a, b,
      input  r, hi, z, v, dz, busy, done
   );

   modport slave (
      input  start, op, a, b,
      output r, hi, z, v, dz, busy, done
   );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle basic ops plus iterative multiply (shift-add) and
// restoring divide on operand magnitudes, with a one-cycle sign-fix step.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic      clk,
   input  logic      rst,
   seq_alu_if.slave  bus
);

   localparam int CW   = SHW + 1;
   localparam int HALF = WIDTH / 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [4:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic               z_q, z_d;
   logic               v_q, v_d;
   logic               dz_q, dz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Operand magnitudes at acceptance; only signed mult/div (op[0]=0) take absolute values.
   logic               signed_in;
   logic [WIDTH-1:0]   mag_a_in, mag_b_in;
   logic               signed_q, neg_q;

   assign signed_in = bus.op[4] & ~bus.op[0];
   assign mag_a_in  = (signed_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign mag_b_in  = (signed_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   assign signed_q  = op_q[4] & ~op_q[0];
   assign neg_q     = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);

   // Basic-op datapath works from the latched operands.
   logic [WIDTH-1:0] basic_r;
   logic             basic_v;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_sum;
   logic [SHW-1:0]   shamt;

   assign add_b   = op_q[2] ? ~b_q : b_q;
   assign add_sum = a_q + add_b + WIDTH'(op_q[2]);
   assign shamt   = a_q[SHW-1:0];

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      basic_r = '0;
      basic_v = 1'b0;
      unique case (op_q[1:0])
         2'b00: begin
            basic_r = add_sum;
            if (op_q[2])
               basic_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            else
               basic_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
         end
         2'b01: basic_r = op_q[2] ? (a_q | b_q) : (a_q & b_q);
         2'b10: basic_r = op_q[2] ? {b_q[HALF-1:0], {HALF{1'b0}}} : (a_q ^ b_q);
         2'b11: begin
            if (!op_q[2])
               basic_r = b_q << shamt;
            else if (op_q[3])
               basic_r = WIDTH'($signed(b_q) >>> shamt);
            else
               basic_r = b_q >> shamt;
         end
         default: basic_r = '0;
      endcase
   end

   // One shift-add step: p holds {partial high, remaining multiplier bits}.
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : '0);

   // One restoring-divide step: p holds {partial remainder, dividend/quotient bits}.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] quo_sh;
   assign rem_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
   assign quo_sh   = {p_q[WIDTH-2:0], 1'b0};
   assign div_diff = rem_sh - {1'b0, mcand_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      mcand_d = mcand_q;
      p_d     = p_q;
      r_d     = r_q;
      hi_d    = hi_q;
      z_d     = z_q;
      v_d     = v_q;
      dz_d    = dz_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d = bus.op;
               a_d  = bus.a;
               b_d  = bus.b;
               if (!bus.op[4]) begin
                  state_d = S_DONE;
               end else if (!bus.op[1]) begin
                  state_d = S_MUL;
                  cnt_d   = CW'(WIDTH);
                  p_d     = {{WIDTH{1'b0}}, mag_b_in};
                  mcand_d = mag_a_in;
               end else if (bus.b == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_DIV;
                  cnt_d   = CW'(WIDTH);
                  p_d     = {{WIDTH{1'b0}}, mag_a_in};
                  mcand_d = mag_b_in;
               end
            end
         end
         S_MUL: begin
            p_d   = {mul_sum, p_q[WIDTH-1:1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_DIV: begin
            if (!div_diff[WIDTH])
               p_d = {div_diff[WIDTH-1:0], quo_sh | WIDTH'(1)};
            else
               p_d = {rem_sh[WIDTH-1:0], quo_sh};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (!op_q[1]) begin
               if (neg_q) p_d = -p_q;
            end else begin
               p_d[WIDTH-1:0]       = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
               p_d[2*WIDTH-1:WIDTH] = (signed_q && a_q[WIDTH-1]) ? -p_q[2*WIDTH-1:WIDTH]
                                                                   : p_q[2*WIDTH-1:WIDTH];
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (!op_q[4]) begin
               r_d  = basic_r;
               hi_d = '0;
               v_d  = basic_v;
               dz_d = 1'b0;
            end else if (op_q[1] && (b_q == '0)) begin
               r_d  = '1;
               hi_d = a_q;
               v_d  = 1'b0;
               dz_d = 1'b1;
            end else begin
               r_d  = p_q[WIDTH-1:0];
               hi_d = p_q[2*WIDTH-1:WIDTH];
               v_d  = 1'b0;
               dz_d = 1'b0;
            end
            z_d = (r_d == '0);
         end
         default: state_d = S_IDLE;
      endcase

      // Busy covers the iterative and sign-fix cycles, dropping as DONE is entered.
      busy_d = (state_d == S_MUL) || (state_d == S_DIV) || (state_d == S_FIX);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mcand_q <= '0;
         p_q     <= '0;
         r_q     <= '0;
         hi_q    <= '0;
         z_q     <= 1'b0;
         v_q     <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mcand_q <= mcand_d;
         p_q     <= p_d;
         r_q     <= r_d;
         hi_q    <= hi_d;
         z_q     <= z_d;
         v_q     <= v_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.r    = r_q;
   assign bus.hi   = hi_q;
   assign bus.z    = z_q;
   assign bus.v    = v_q;
   assign bus.dz   = dz_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table with hand-computed results, then
// sequences for busy length, ignored starts, and reset during an operation.
module tb_seq_alu;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   busy_cnt;

   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(32), .SHW(5)) bif ();

   seq_alu #(.WIDTH(32), .SHW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [31:0] hi;
      logic        z;
      logic        v;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[21];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request, scramble the inputs after acceptance, wait for done.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      @(negedge clk);
      bif.start = 1'b1;
      bif.op    = op;
      bif.a     = a;
      bif.b     = b;
      @(posedge clk); #1;
      bif.start = 1'b0;
      bif.op    = ~op;
      bif.a     = ~a;
      bif.b     = b ^ 32'h5A5A_0F0F;
      busy_cnt  = int'(bif.busy);
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (bif.done) break;
         busy_cnt += int'(bif.busy);
      end
   endtask

   initial begin
      int lat;
      int done_seen;

      vecs[0]  = '{"add_ovf",   5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1};
      vecs[1]  = '{"sub_zero",  5'b00100, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
      vecs[2]  = '{"sub_ovf",   5'b00100, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1};
      vecs[3]  = '{"mult",      5'b10000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 34};
      vecs[4]  = '{"and",       5'b00001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
      vecs[5]  = '{"or",        5'b00101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'h0, 1'b0, 1'b0, 1'b0, 1};
      vecs[6]  = '{"xor",       5'b00010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 1'b0, 1'b0, 1'b0, 1};
      vecs[7]  = '{"lui",       5'b00110, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{"sll31",     5'b00011, 32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
      vecs[9]  = '{"srl",       5'b00111, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
      vecs[10] = '{"sra",       5'b01111, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1};
      vecs[11] = '{"multu",     5'b10001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 1'b0, 34};
      vecs[12] = '{"div_neg",   5'b10010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 34};
      vecs[13] = '{"divu",      5'b10011, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 32'h1, 1'b0, 1'b0, 1'b0, 34};
      vecs[14] = '{"divu_dz",   5'b10011, 32'h0000_0055, 32'h0000_0000, 32'hFFFF_FFFF, 32'h55, 1'b0, 1'b0, 1'b1, 1};
      vecs[15] = '{"div_minm1", 5'b10010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 34};
      vecs[16] = '{"mult_min",  5'b10000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1, 1'b0, 1'b0, 34};
      vecs[17] = '{"div_negb",  5'b10010, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0, 1'b0, 1'b0, 34};
      vecs[18] = '{"add_carry", 5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1};
      vecs[19] = '{"div_dz",    5'b10010, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 1};
      vecs[20] = '{"mult_op32", 5'b11100, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 32'h0, 1'b0, 1'b0, 1'b0, 34};

      rst       = 1'b1;
      bif.start = 1'b0;
      bif.op    = '0;
      bif.a     = '0;
      bif.b     = '0;
      #13;
      check("rst_r",    64'(bif.r),    64'h0);
      check("rst_hi",   64'(bif.hi),   64'h0);
      check("rst_busy", 64'(bif.busy), 64'h0);
      check("rst_done", 64'(bif.done), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 21; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check({vecs[i].name, "_lat"}, 64'(lat),      64'(vecs[i].lat));
         check({vecs[i].name, "_r"},   64'(bif.r),    64'(vecs[i].r));
         check({vecs[i].name, "_hi"},  64'(bif.hi),   64'(vecs[i].hi));
         check({vecs[i].name, "_z"},   64'(bif.z),    64'(vecs[i].z));
         check({vecs[i].name, "_v"},   64'(bif.v),    64'(vecs[i].v));
         check({vecs[i].name, "_dz"},  64'(bif.dz),   64'(vecs[i].dz));
      end

      // Busy must stay high for 33 sampled cycles of a 32-bit multiply.
      run_op(5'b10000, 32'hFFFF_FFFD, 32'h0000_0005, lat);
      check("mult_busy_cycles", 64'(busy_cnt), 64'd33);
      check("mult_busy_at_done", 64'(bif.busy), 64'h0);

      // Start pulses while busy must not disturb the multiply in progress.
      @(negedge clk);
      bif.start = 1'b1; bif.op = 5'b10000; bif.a = 32'hFFFF_FFFD; bif.b = 32'h0000_0005;
      @(posedge clk); #1;
      bif.start = 1'b0;
      lat = 0;
      while (lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 5) begin
            bif.start = 1'b1; bif.op = 5'b00000; bif.a = 32'h1; bif.b = 32'h1;
         end
         if (lat == 8) bif.start = 1'b0;
         if (bif.done) break;
      end
      check("busy_start_lat", 64'(lat),    64'd34);
      check("busy_start_r",   64'(bif.r),  64'hFFFF_FFF1);
      check("busy_start_hi",  64'(bif.hi), 64'hFFFF_FFFF);

      // Start held through the DONE cycle is ignored; results then hold.
      @(negedge clk);
      bif.start = 1'b1; bif.op = 5'b00000; bif.a = 32'h1; bif.b = 32'h1;
      @(posedge clk); #1;
      bif.a = 32'hA; bif.b = 32'hA;
      @(posedge clk); #1;
      check("done_cycle_done", 64'(bif.done), 64'h1);
      check("done_cycle_r",    64'(bif.r),    64'h2);
      bif.start = 1'b0;
      @(posedge clk); #1;
      check("done_cycle_no_second", 64'(bif.done), 64'h0);
      check("hold_r",               64'(bif.r),    64'h2);
      repeat (3) @(posedge clk);
      #1;
      check("hold_r_later", 64'(bif.r), 64'h2);

      // Reset ten edges into a multiply clears everything at once, with no done afterwards.
      run_op(5'b10001, 32'hFFFF_FFFF, 32'h0000_0002, lat);
      @(negedge clk);
      bif.start = 1'b1; bif.op = 5'b10000; bif.a = 32'hFFFF_FFFD; bif.b = 32'h0000_0005;
      @(posedge clk); #1;
      bif.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("pre_rst_busy", 64'(bif.busy), 64'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_r",    64'(bif.r),    64'h0);
      check("mid_rst_hi",   64'(bif.hi),   64'h0);
      check("mid_rst_z",    64'(bif.z),    64'h0);
      check("mid_rst_v",    64'(bif.v),    64'h0);
      check("mid_rst_dz",   64'(bif.dz),   64'h0);
      check("mid_rst_busy", 64'(bif.busy), 64'h0);
      check("mid_rst_done", 64'(bif.done), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bif.done) done_seen++;
      end
      check("post_rst_no_done", 64'(done_seen), 64'h0);
      run_op(5'b10000, 32'hFFFF_FFFD, 32'h0000_0005, lat);
      check("post_rst_lat", 64'(lat),    64'd34);
      check("post_rst_r",   64'(bif.r),  64'hFFFF_FFF1);
      check("post_rst_hi",  64'(bif.hi), 64'hFFFF_FFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
